crc8_frame_gen: RTL and testbench

Bit-serial CRC-8 generator for the transmit side of the SPI command link. It takes a 49-bit payload, computes CRC-8 (polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR) one bit per clock, and returns a 57-bit frame: payload in bits 56:8, CRC in bits 7:0. The downstream 57-bit frame checker in the receive path accepts this frame as valid. An optional serializer shifts the frame out MSB-first.

---
 rtl/crc8_frame_gen.sv | 147 ++++++++++++++
 tb/tb_crc8_frame_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/crc8_frame_gen.sv
// Bit-serial CRC-8 frame generator: 49-bit payload + 8-bit CRC -> 57-bit frame.
// Optional MSB-first serializer enabled by defining CRC8_FRAME_GEN_SERIAL_OUT_EN.
module crc8_frame_gen #(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [48:0] din,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [56:0] frame,
    output logic        sdo,
    output logic        sdo_valid,
    output logic        sdo_last
);

`ifdef CRC8_FRAME_GEN_SERIAL_OUT_EN
    typedef enum logic [1:0] {IDLE, CALC, SHIFT} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC} state_t;
`endif

    state_t      state_q, state_d;
    logic [48:0] payload_q, payload_d;
    logic [7:0]  crc_q, crc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [56:0] frame_q, frame_d;
    logic        fb;

`ifdef CRC8_FRAME_GEN_SERIAL_OUT_EN
    logic [56:0] sh_q, sh_d;
    logic        sdo_valid_q, sdo_valid_d;
    logic        sdo_last_q, sdo_last_d;
`endif

    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        frame_d   = frame_q;
        fb        = payload_q[48] ^ crc_q[7];
`ifdef CRC8_FRAME_GEN_SERIAL_OUT_EN
        sh_d        = sh_q;
        sdo_valid_d = sdo_valid_q;
        sdo_last_d  = sdo_last_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    payload_d = din;
                    crc_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
                // Rotate rather than shift: after 49 steps the original payload is back in place.
                payload_d = {payload_q[47:0], payload_q[48]};
                cnt_d     = 6'(cnt_q + 6'd1);
                if (cnt_q == 6'd48) begin
                    frame_d = {payload_d, crc_d};
                    done_d  = 1'b1;
                    cnt_d   = '0;
`ifdef CRC8_FRAME_GEN_SERIAL_OUT_EN
                    sh_d        = frame_d;
                    sdo_valid_d = 1'b1;
                    sdo_last_d  = 1'b0;
                    state_d     = SHIFT;
`else
                    busy_d  = 1'b0;
                    state_d = IDLE;
`endif
                end
            end
`ifdef CRC8_FRAME_GEN_SERIAL_OUT_EN
            SHIFT: begin
                if (cnt_q == 6'd56) begin
                    sh_d        = '0;
                    sdo_valid_d = 1'b0;
                    sdo_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    sh_d       = {sh_q[55:0], 1'b0};
                    cnt_d      = 6'(cnt_q + 6'd1);
                    sdo_last_d = (cnt_q == 6'd55);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            payload_q <= '0;
            crc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            frame_q   <= '0;
`ifdef CRC8_FRAME_GEN_SERIAL_OUT_EN
            sh_q        <= '0;
            sdo_valid_q <= 1'b0;
            sdo_last_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            frame_q   <= frame_d;
`ifdef CRC8_FRAME_GEN_SERIAL_OUT_EN
            sh_q        <= sh_d;
            sdo_valid_q <= sdo_valid_d;
            sdo_last_q  <= sdo_last_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign frame = frame_q;

`ifdef CRC8_FRAME_GEN_SERIAL_OUT_EN
    assign sdo       = sh_q[56];
    assign sdo_valid = sdo_valid_q;
    assign sdo_last  = sdo_last_q;
`else
    assign sdo       = 1'b0;
    assign sdo_valid = 1'b0;
    assign sdo_last  = 1'b0;
`endif

endmodule

// File: tb/tb_crc8_frame_gen.sv
// Directed and random self-checking bench for crc8_frame_gen.
// Serializer checks are active when CRC8_FRAME_GEN_SERIAL_OUT_EN is defined.
module tb_crc8_frame_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [48:0] din = '0;
    logic        start = 1'b0;
    logic        busy, done, sdo, sdo_valid, sdo_last;
    logic [56:0] frame;

    int checks = 0;
    int errors = 0;

    crc8_frame_gen #(.POLY(8'h07)) dut (
        .clk(clk), .rst(rst), .din(din), .start(start),
        .busy(busy), .done(done), .frame(frame),
        .sdo(sdo), .sdo_valid(sdo_valid), .sdo_last(sdo_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Receive-side checker: CRC over the whole frame is zero for a valid frame.
    function automatic logic [7:0] crc57(input logic [56:0] f);
        logic [7:0] c;
        logic       b;
        c = '0;
        for (int i = 56; i >= 0; i--) begin
            b = f[i] ^ c[7];
            c = {c[6:0], 1'b0} ^ (b ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Issue start on the next edge (E0), then wait for done; returns edges from E0 to done.
    task automatic launch_and_wait(input logic [48:0] d, output int lat);
        start = 1'b1;
        din   = d;
        step();
        start = 1'b0;
        din   = '0;
        lat   = 0;
        while (done !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        check("idle_timeout", 64'(n < 200), 64'd1);
    endtask

    task automatic directed(input string tag, input logic [48:0] d, input logic [56:0] exp_f);
        int lat;
        launch_and_wait(d, lat);
        check({tag, "_latency"}, 64'(lat), 64'd49);
        check({tag, "_frame"}, 64'(frame), 64'(exp_f));
`ifndef CRC8_FRAME_GEN_SERIAL_OUT_EN
        check({tag, "_busy_clr"}, 64'(busy), 64'd0);
`endif
        step();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        wait_idle();
    endtask

    initial begin
        int lat;
        int done_cnt;
        logic [48:0] r;

        // Reset state
        step(); step(); step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_frame", 64'(frame), 64'd0);
        check("rst_sdo", 64'(sdo), 64'd0);
        check("rst_sdo_valid", 64'(sdo_valid), 64'd0);
        check("rst_sdo_last", 64'(sdo_last), 64'd0);
        rst = 1'b0;
        step();

        // Reset mid-CALC: start at E0, reset at E20
        start = 1'b1; din = 49'h1;
        step();
        start = 1'b0; din = '0;
        check("abort_busy_set", 64'(busy), 64'd1);
        for (int i = 1; i < 20; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        directed("after_abort", 49'h1, 57'h107);

        // Known vectors
        directed("vec0", 49'h0, 57'h0);
        directed("vec1", 49'h1, 57'h107);
        directed("vec2", 49'h2, 57'h20E);
        directed("vec80", 49'h80, 57'h8089);

        // Busy rejection: extra starts at E10 and E49
        start = 1'b1; din = 49'h1;
        step();
        start = 1'b0; din = '0;
        for (int i = 1; i < 10; i++) step();
        start = 1'b1; din = 49'h2;
        step();
        start = 1'b0; din = '0;
        for (int i = 11; i < 49; i++) step();
        start = 1'b1; din = 49'h2;
        step();
        start = 1'b0; din = '0;
        check("rej_done_e49", 64'(done), 64'd1);
        check("rej_frame", 64'(frame), 64'h107);
        done_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        check("rej_no_extra_done", 64'(done_cnt), 64'd0);
        check("rej_frame_held", 64'(frame), 64'h107);
        check("rej_busy", 64'(busy), 64'd0);

`ifndef CRC8_FRAME_GEN_SERIAL_OUT_EN
        // Back-to-back: second start at E50
        launch_and_wait(49'h2, lat);
        check("b2b_lat1", 64'(lat), 64'd49);
        check("b2b_frame1", 64'(frame), 64'h20E);
        launch_and_wait(49'h80, lat);
        check("b2b_lat2", 64'(lat), 64'd49);
        check("b2b_frame2", 64'(frame), 64'h8089);
        step();
`else
        // Serializer: capture the stream for din=1
        begin
            logic [56:0] cap;
            int nvalid, nlast, lastpos, n;
            cap = '0; nvalid = 0; nlast = 0; lastpos = -1;
            launch_and_wait(49'h1, lat);
            check("ser_lat", 64'(lat), 64'd49);
            n = 0;
            while (sdo_valid === 1'b1 && n < 100) begin
                cap = {cap[55:0], sdo};
                nvalid++;
                if (sdo_last === 1'b1) begin
                    nlast++;
                    lastpos = nvalid;
                end
                check("ser_busy_during", 64'(busy), 64'd1);
                step();
                n++;
            end
            check("ser_nvalid", 64'(nvalid), 64'd57);
            check("ser_bits", 64'(cap), 64'h107);
            check("ser_nlast", 64'(nlast), 64'd1);
            check("ser_lastpos", 64'(lastpos), 64'd57);
            check("ser_busy_fall_e106", 64'(busy), 64'd0);
            check("ser_sdo_last_clr", 64'(sdo_last), 64'd0);
        end
`endif

        // Random payloads checked by the receive-side CRC property
        for (int k = 0; k < 1000; k++) begin
            r = {$urandom(), $urandom()};
            launch_and_wait(r, lat);
            check("rnd_latency", 64'(lat), 64'd49);
            check("rnd_payload", 64'(frame[56:8]), 64'(r));
            check("rnd_crc_zero", 64'(crc57(frame)), 64'd0);
            step();
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
